bus_arbiter: RTL and testbench

Round-robin arbiter that shares one tri-state system bus among REQUESTERS masters on the motherboard. It issues one-hot grants that drive the output-enable of each master's TRIBUFFER. A mandatory one-cycle turnaround between owners guarantees no two drivers overlap. An optional hold-timeout watchdog revokes a grant from a master that holds the bus too long.

---
 rtl/bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for a shared tri-state bus.
// One-hot grant drives each master's TRIBUFFER output enable; every change of
// owner passes through a one-cycle all-low TURNAROUND so drivers never overlap.
// Optional hold-timeout watchdog: define BUS_ARBITER_TIMEOUT_EN to build it.
//
// state      | meaning
// -----------+--------------------------------------------------
// S_IDLE     | no owner, all grants low
// S_GRANTED  | one owner, exactly one grant bit high
// S_TURNAROUND | bus gap cycle after a release or revoke
module bus_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQUESTERS-1:0]         req,
    output logic [REQUESTERS-1:0]         grant,
    output logic [$clog2(REQUESTERS)-1:0] grant_id,
    output logic                          busy,
    output logic                          timeout
);

    localparam int W = $clog2(REQUESTERS);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_GRANTED    = 2'd1,
        S_TURNAROUND = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [W-1:0]          last_owner;
    logic [W-1:0]          last_owner_nxt;
    logic [REQUESTERS-1:0] grant_nxt;
    logic [W-1:0]          grant_id_nxt;
    logic                  busy_nxt;
    logic                  timeout_nxt;

    logic [REQUESTERS-1:0] eligible;
    logic [REQUESTERS-1:0] elig_rot;
    logic                  win_found;
    logic [W-1:0]          win_idx;
    int                    cand;
    logic                  owner_req;
    logic                  fire;

    // While GRANTED the owner is always last_owner, since it updates on every grant.
    assign owner_req = req[last_owner];

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [7:0]            hold_cnt;
    logic [REQUESTERS-1:0] penalty;

    assign eligible = req & ~penalty;
    // Fire on the edge where the count would reach TIMEOUT with the owner still requesting.
    assign fire = (state == S_GRANTED) && owner_req && (hold_cnt == 8'(TIMEOUT - 1));

    // Hold counter: zero outside GRANTED, counts requesting GRANTED cycles, saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state != S_GRANTED) begin
            hold_cnt <= '0;
        end else if (owner_req && (hold_cnt != 8'hFF)) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // Penalty: set on the revoked owner, cleared by the first sampled low request.
    always_ff @(posedge clk) begin
        if (rst) begin
            penalty <= '0;
        end else begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (fire && (last_owner == W'(i))) begin
                    penalty[i] <= 1'b1;
                end else if (!req[i]) begin
                    penalty[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign eligible = req;
    assign fire     = 1'b0;
`endif

    // Rotate so bit 0 is the requester just after last_owner (lowest priority = last_owner).
    assign elig_rot = REQUESTERS'({eligible, eligible} >> (int'(last_owner) + 1));

    // First eligible requester in round-robin order after last_owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (!win_found && elig_rot[i]) begin
                win_found = 1'b1;
                cand      = int'(last_owner) + 1 + i;
                if (cand >= REQUESTERS) begin
                    cand = cand - REQUESTERS;
                end
                win_idx = W'(cand);
            end
        end
    end

    // Next-state and next registered outputs.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        grant_nxt      = '0;
        grant_id_nxt   = '0;
        busy_nxt       = 1'b0;
        timeout_nxt    = 1'b0;
        case (state)
            S_IDLE, S_TURNAROUND: begin
                if (win_found) begin
                    state_nxt      = S_GRANTED;
                    last_owner_nxt = win_idx;
                    grant_nxt      = {{(REQUESTERS-1){1'b0}}, 1'b1} << win_idx;
                    grant_id_nxt   = win_idx;
                    busy_nxt       = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_GRANTED: begin
                if (!owner_req || fire) begin
                    state_nxt   = S_TURNAROUND;
                    timeout_nxt = fire;
                end else begin
                    grant_nxt    = grant;
                    grant_id_nxt = grant_id;
                    busy_nxt     = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops grant at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_owner <= W'(REQUESTERS - 1);
            grant      <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            grant      <= grant_nxt;
            grant_id   <= grant_id_nxt;
            busy       <= busy_nxt;
            timeout    <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: reference model feeds an expectation queue,
// a negedge monitor pops and compares every cycle.
module tb_bus_arbiter;

    localparam int N   = 4;
    localparam int TMO = 4;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [1:0]   id;
        logic         busy;
        logic         tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_owner;
    int   m_last;
    int   m_hold;
    bit   m_pen[N];

    bit           rec_en = 1'b0;
    int           seen_ids[$];
    int           to_pulses = 0;
    logic [N-1:0] prev_grant = '0;

    bus_arbiter #(.REQUESTERS(N), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Reference: an owner exists or not; with no owner, the first eligible
    // requester after the previous owner is taken.
    task automatic model_step(input bit r_rst, input logic [N-1:0] r);
        exp_t e;
        bit   tmo;
        tmo = 1'b0;
        if (r_rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_hold  = 0;
            for (int i = 0; i < N; i++) m_pen[i] = 1'b0;
        end else begin
            if (m_owner >= 0) begin
                if (!r[m_owner]) begin
                    m_owner = -1;
                end else if (TO_EN && (m_hold + 1 >= TMO)) begin
                    m_pen[m_owner] = 1'b1;
                    m_owner = -1;
                    tmo = 1'b1;
                end else if (m_hold < 255) begin
                    m_hold++;
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_last + k) % N;
                    if (r[idx] && !m_pen[idx]) begin
                        m_owner = idx;
                        m_last  = idx;
                        m_hold  = 0;
                        break;
                    end
                end
            end
            for (int i = 0; i < N; i++) if (!r[i]) m_pen[i] = 1'b0;
        end
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.busy  = (m_owner >= 0);
        e.tmo   = tmo;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r_rst, input logic [N-1:0] r);
        @(negedge clk);
        #1;
        rst = r_rst;
        req = r;
        model_step(r_rst, r);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic check_order(input string name, input int exp_ids[$]);
        bit ok;
        ok = (seen_ids.size() == exp_ids.size());
        if (ok) begin
            for (int k = 0; k < exp_ids.size(); k++) begin
                if (seen_ids[k] != exp_ids[k]) ok = 1'b0;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got ids %p, required %p", name, seen_ids, exp_ids);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, want);
        end
    endtask

    // Monitor: one expectation per clock, compared away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (grant !== e.grant || grant_id !== e.id || busy !== e.busy || timeout !== e.tmo) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t: got grant=%b id=%0d busy=%b timeout=%b, required grant=%b id=%0d busy=%b timeout=%b",
                         $time, grant, grant_id, busy, timeout, e.grant, e.id, e.busy, e.tmo);
            end
            if (rec_en && (grant != '0) && (prev_grant == '0)) seen_ids.push_back(int'(grant_id));
            if (rec_en && (timeout === 1'b1)) to_pulses++;
            prev_grant = grant;
        end
    end

    initial begin
        int exp_ids[$];
        logic [N-1:0] rq;
        int order[$];

        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);

        // Single request, then release.
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);

        // All requesting; each owner drops for one cycle after 3 granted cycles.
        step(1'b1, 4'b0000);
        seen_ids.delete();
        rec_en = 1'b1;
        order = {0, 1, 2, 3, 0};
        foreach (order[t]) begin
            for (int c = 0; c < 3; c++) step(1'b0, 4'b1111);
            step(1'b0, 4'b1111 & ~(4'b0001 << order[t]));
        end
        drain();
        rec_en = 1'b0;
        exp_ids = {0, 1, 2, 3, 0};
        check_order("rr_order", exp_ids);

        // Owner 2 releases with 1 waiting: search wraps 3 -> 0 -> 1.
        step(1'b1, 4'b0000);
        seen_ids.delete();
        rec_en = 1'b1;
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0110);
        step(1'b0, 4'b0110);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        drain();
        rec_en = 1'b0;
        exp_ids = {2, 1};
        check_order("wrap_order", exp_ids);

        // Reset while owner 2 holds the bus, then regrant.
        step(1'b1, 4'b0000);
        seen_ids.delete();
        rec_en = 1'b1;
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        step(1'b1, 4'b0100);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0000);
        drain();
        rec_en = 1'b0;
        exp_ids = {2, 2};
        check_order("reset_regrant", exp_ids);

        // Long hold by requester 1.
        step(1'b1, 4'b0000);
        seen_ids.delete();
        to_pulses = 0;
        rec_en = 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
        for (int c = 0; c < 14; c++) step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        drain();
        rec_en = 1'b0;
        exp_ids = {1, 1};
        check_order("timeout_regrant", exp_ids);
        check_int("timeout_pulses", to_pulses, 1);
`else
        for (int c = 0; c < 300; c++) step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        drain();
        rec_en = 1'b0;
        exp_ids = {1};
        check_order("long_hold", exp_ids);
        check_int("timeout_pulses", to_pulses, 0);
`endif

        // Randomized traffic with sticky requests and occasional reset.
        step(1'b1, 4'b0000);
        rq = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            end
            step(($urandom_range(0, 299) == 0), rq);
        end
        step(1'b0, 4'b0000);
        drain();
        drain();

        check_int("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
